axil_ram_responder: RTL and testbench

- AXI4-Lite slave (responder) backed by a byte-writable synchronous word RAM.
- It is the far end of the CPU's instruction-memory and data-memory AXI-Lite initiators, used as a simulation/FPGA stand-in for DDR and as on-chip scratch RAM.
- Read and write channels are independent and can proceed concurrently.

---
 rtl/axil_ram_responder_pkg.sv | 20 ++
 rtl/axil_ram_bram.sv | 41 ++++
 rtl/axil_ram_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_axil_ram_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_ram_responder_pkg.sv
// Shared constants and FSM state encodings for the AXI4-Lite RAM responder.
// Imported by axil_ram_bram and axil_ram_responder.
package axil_ram_responder_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int FSM_STATE_W = 1;

    typedef enum logic [FSM_STATE_W-1:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic [FSM_STATE_W-1:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_e;

endpackage

// File: rtl/axil_ram_bram.sv
// Word RAM with one byte-enabled write port and one synchronous read port.
// A read and a write to the same word on one edge return the old contents (read-first).
module axil_ram_bram
    import axil_ram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // No reset on the read register so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axil_ram_responder.sv
// AXI4-Lite responder backed by axil_ram_bram; read and write channels run independently.
// Optional macro AXIL_RAM_RANGE_CHECK_EN: out-of-window accesses return SLVERR instead of aliasing.
module axil_ram_responder
    import axil_ram_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset_N,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int STRB_W = DATA_WIDTH / 8;

    w_state_e                w_state_q, w_state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;

    r_state_e                r_state_q, r_state_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rerr_q, rerr_d;

    logic                    aw_fire, w_fire, ar_fire;
    logic                    aw_have, w_have;
    logic [ADDR_WIDTH-1:0]   w_addr_sel;
    logic [DATA_WIDTH-1:0]   w_data_sel;
    logic [STRB_W-1:0]       w_strb_sel;
    logic [ADDR_WIDTH-1:0]   w_off, r_off;
    logic                    w_in_range, r_in_range;
    logic                    ram_we, ram_re;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic                    unused_off_bits;

    assign aw_fire    = s_axil_awvalid && awready_q;
    assign w_fire     = s_axil_wvalid && wready_q;
    assign ar_fire    = s_axil_arvalid && arready_q;
    assign aw_have    = aw_held_q || aw_fire;
    assign w_have     = w_held_q || w_fire;
    assign w_addr_sel = aw_held_q ? awaddr_q : s_axil_awaddr;
    assign w_data_sel = w_held_q ? wdata_q : s_axil_wdata;
    assign w_strb_sel = w_held_q ? wstrb_q : s_axil_wstrb;

    // Offsets are relative to the RAM window; the byte lane bits are ignored.
    assign w_off = w_addr_sel - BASE_ADDR;
    assign r_off = s_axil_araddr - BASE_ADDR;

`ifdef AXIL_RAM_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;
    assign w_in_range = ({1'b0, w_off} < SPAN);
    assign r_in_range = ({1'b0, r_off} < SPAN);
`else
    assign w_in_range = 1'b1;
    assign r_in_range = 1'b1;
`endif

    assign unused_off_bits = ^{w_off, r_off};

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ram_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) awaddr_d = s_axil_awaddr;
                if (w_fire) begin
                    wdata_d = s_axil_wdata;
                    wstrb_d = s_axil_wstrb;
                end
                // Commit on the edge where both halves are present, whichever came last.
                if (aw_have && w_have) begin
                    ram_we    = w_in_range;
                    bvalid_d  = 1'b1;
                    bresp_d   = w_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    aw_held_d = aw_have;
                    w_held_d  = w_have;
                    awready_d = !aw_have;
                    wready_d  = !w_have;
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rerr_d    = rerr_q;
        ram_re    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_fire) begin
                    ram_re    = 1'b1;
                    rvalid_d  = 1'b1;
                    rresp_d   = r_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    rerr_d    = !r_in_range;
                    arready_d = 1'b0;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axil_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= AXI_RESP_OKAY;
            rerr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rerr_q    <= rerr_d;
        end
    end

    axil_ram_bram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bram (
        .clock   (i_Clock),
        .wr_en   (ram_we),
        .wr_idx  (w_off[IDX_W+1:2]),
        .wr_be   (w_strb_sel),
        .wr_data (w_data_sel),
        .rd_en   (ram_re),
        .rd_idx  (r_off[IDX_W+1:2]),
        .rd_data (ram_rdata)
    );

    // The RAM read register is not reset, so rdata is forced to zero outside a valid in-range beat.
    assign s_axil_rdata   = (rvalid_q && !rerr_q) ? ram_rdata : '0;
    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_ram_responder.sv
// Self-checking bench for axil_ram_responder: directed transactions plus a per-cycle reference model.
// Expectations follow AXIL_RAM_RANGE_CHECK_EN when it is defined.
module tb_axil_ram_responder;

    localparam int          DEPTH  = 64;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
`ifdef AXIL_RAM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int checks = 0;
    int failures = 0;

    axil_ram_responder #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .i_Clock        (clock),
        .i_Reset_N      (reset_n),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a plain word array plus the per-channel transaction bookkeeping.
    logic [31:0] mem_model [DEPTH];
    bit          m_fresh = 1'b1;
    bit          m_aw_pend, m_w_pend, m_b_out, m_r_out;
    logic [31:0] m_aw_addr, m_w_data;
    logic [3:0]  m_w_strb;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp, m_bresp;

    function automatic bit in_window(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off / 4) % DEPTH;
    endfunction

    initial begin : monitor
        bit e_awready, e_wready, e_arready, aw_hs, w_hs, ar_hs, b_hs, r_hs;
        int idx;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                checkOutput("rst_awready", awready, 0);
                checkOutput("rst_wready", wready, 0);
                checkOutput("rst_bvalid", bvalid, 0);
                checkOutput("rst_arready", arready, 0);
                checkOutput("rst_rvalid", rvalid, 0);
                checkOutput("rst_bresp", bresp, 0);
                checkOutput("rst_rresp", rresp, 0);
                checkOutput("rst_rdata", rdata, 0);
                m_fresh = 1'b1;
                m_aw_pend = 0; m_w_pend = 0; m_b_out = 0; m_r_out = 0;
            end else if (m_fresh) begin
                checkOutput("release_awready", awready, 0);
                checkOutput("release_arready", arready, 0);
                m_fresh = 1'b0;
            end else begin
                e_awready = !m_b_out && !m_aw_pend;
                e_wready  = !m_b_out && !m_w_pend;
                e_arready = !m_r_out;
                checkOutput("awready", awready, e_awready);
                checkOutput("wready", wready, e_wready);
                checkOutput("bvalid", bvalid, m_b_out);
                checkOutput("arready", arready, e_arready);
                checkOutput("rvalid", rvalid, m_r_out);
                if (m_b_out) checkOutput("bresp", bresp, m_bresp);
                if (m_r_out) begin
                    checkOutput("rdata", rdata, m_rdata);
                    checkOutput("rresp", rresp, m_rresp);
                end
                aw_hs = awvalid && e_awready;
                w_hs  = wvalid && e_wready;
                ar_hs = arvalid && e_arready;
                b_hs  = m_b_out && bready;
                r_hs  = m_r_out && rready;
                if (b_hs) m_b_out = 0;
                if (r_hs) m_r_out = 0;
                // Reads are served before a write landing on the same edge.
                if (ar_hs) begin
                    m_r_out = 1;
                    if (RANGE_EN && !in_window(araddr)) begin
                        m_rdata = 0; m_rresp = SLVERR;
                    end else begin
                        m_rdata = mem_model[word_of(araddr)]; m_rresp = OKAY;
                    end
                end
                if (aw_hs) begin m_aw_addr = awaddr; m_aw_pend = 1; end
                if (w_hs) begin m_w_data = wdata; m_w_strb = wstrb; m_w_pend = 1; end
                if (m_aw_pend && m_w_pend) begin
                    if (RANGE_EN && !in_window(m_aw_addr)) begin
                        m_bresp = SLVERR;
                    end else begin
                        m_bresp = OKAY;
                        idx = word_of(m_aw_addr);
                        for (int i = 0; i < 4; i++)
                            if (m_w_strb[i]) mem_model[idx][i*8 +: 8] = m_w_data[i*8 +: 8];
                    end
                    m_b_out = 1; m_aw_pend = 0; m_w_pend = 0;
                end
            end
        end
    end

    // One write: AW and W raised after their own delays, bready raised ready_delay cycles after bvalid.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                 input int aw_delay, input int w_delay, input int ready_delay,
                                 output logic [1:0] resp);
        bit aw_done, w_done;
        int n;
        aw_done = 0; w_done = 0; resp = 2'bxx;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = (aw_delay == 0);
        wvalid = (w_delay == 0);
        bready = (ready_delay == 0);
        n = 0;
        while (!(aw_done && w_done) && n < 40) begin
            @(negedge clock);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(posedge clock); #1;
            n++;
            if (aw_done) awvalid = 0; else if (n >= aw_delay) awvalid = 1;
            if (w_done) wvalid = 0; else if (n >= w_delay) wvalid = 1;
            if (aw_done && !w_done) begin
                checkOutput("awready_low_while_aw_held", awready, 0);
                checkOutput("no_bvalid_before_w", bvalid, 0);
            end
        end
        checkOutput("write_handshake_in_time", aw_done && w_done, 1);
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clock); #1; n++; end
        repeat (ready_delay) begin @(posedge clock); #1; end
        bready = 1;
        @(negedge clock);
        checkOutput("bvalid_present", bvalid, 1);
        resp = bresp;
        @(posedge clock); #1;
        bready = 0;
        awvalid = 0; wvalid = 0;
    endtask

    task automatic readWord(input logic [31:0] a, input int ready_delay,
                            output logic [31:0] d, output logic [1:0] resp);
        bit ar_done;
        int n;
        ar_done = 0; d = 'x; resp = 2'bxx;
        araddr = a; arvalid = 1;
        rready = (ready_delay == 0);
        n = 0;
        while (!ar_done && n < 40) begin
            @(negedge clock);
            if (arready) ar_done = 1;
            @(posedge clock); #1;
            n++;
        end
        arvalid = 0;
        checkOutput("read_handshake_in_time", ar_done, 1);
        n = 0;
        while (!rvalid && n < 20) begin @(posedge clock); #1; n++; end
        repeat (ready_delay) begin @(posedge clock); #1; end
        rready = 1;
        @(negedge clock);
        checkOutput("rvalid_present", rvalid, 1);
        d = rdata; resp = rresp;
        @(posedge clock); #1;
        rready = 0;
    endtask

    logic [1:0]  b_r, r_r;
    logic [31:0] d_r, d2_r;

    initial begin : stimulus
        int n;
        repeat (3) @(posedge clock);
        #1 reset_n = 1;
        repeat (2) begin @(posedge clock); #1; end

        applyStimulus(BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, b_r);
        checkOutput("single_write_bresp", b_r, OKAY);
        readWord(BASE + 32'h10, 0, d_r, r_r);
        checkOutput("single_read_rdata", d_r, 32'hDEAD_BEEF);
        checkOutput("single_read_rresp", r_r, OKAY);

        applyStimulus(BASE + 32'h20, 32'h1122_3344, 4'b1111, 0, 0, 0, b_r);
        applyStimulus(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, b_r);
        readWord(BASE + 32'h22, 0, d_r, r_r);
        checkOutput("partial_write_rdata", d_r, 32'h11BB_33DD);

        applyStimulus(BASE + 32'h30, 32'h5A5A_5A5A, 4'b1111, 0, 3, 0, b_r);
        checkOutput("aw_first_bresp", b_r, OKAY);
        applyStimulus(BASE + 32'h34, 32'hA5A5_0001, 4'b1111, 2, 0, 0, b_r);
        readWord(BASE + 32'h30, 0, d_r, r_r);
        checkOutput("aw_first_rdata", d_r, 32'h5A5A_5A5A);
        readWord(BASE + 32'h34, 0, d_r, r_r);
        checkOutput("w_first_rdata", d_r, 32'hA5A5_0001);

        applyStimulus(BASE + 32'h10, 32'h0000_0000, 4'b0000, 0, 0, 0, b_r);
        checkOutput("zero_strobe_bresp", b_r, OKAY);
        readWord(BASE + 32'h10, 0, d_r, r_r);
        checkOutput("zero_strobe_rdata", d_r, 32'hDEAD_BEEF);

        fork
            applyStimulus(BASE + 32'h50, 32'h0F0F_0F0F, 4'b1111, 0, 0, 5, b_r);
            readWord(BASE + 32'h20, 5, d_r, r_r);
        join
        checkOutput("backpressure_bresp", b_r, OKAY);
        checkOutput("backpressure_rdata", d_r, 32'h11BB_33DD);

        applyStimulus(BASE + 32'h40, 32'h0000_0001, 4'b1111, 0, 0, 0, b_r);
        fork
            applyStimulus(BASE + 32'h40, 32'h0000_0002, 4'b1111, 0, 0, 0, b_r);
            readWord(BASE + 32'h40, 0, d_r, r_r);
        join
        checkOutput("collision_old_data", d_r, 32'h0000_0001);
        readWord(BASE + 32'h40, 0, d_r, r_r);
        checkOutput("collision_new_data", d_r, 32'h0000_0002);

        applyStimulus(BASE, 32'hCAFE_F00D, 4'b1111, 0, 0, 0, b_r);
        applyStimulus(BASE + 32'hFC, 32'h6363_6363, 4'b1111, 0, 0, 0, b_r);
        applyStimulus(BASE + 32'h100, 32'h1234_5678, 4'b1111, 0, 0, 0, b_r);
        checkOutput("range_hi_bresp", b_r, RANGE_EN ? SLVERR : OKAY);
        readWord(BASE + 32'h100, 0, d_r, r_r);
        checkOutput("range_hi_rdata", d_r, RANGE_EN ? 32'h0 : 32'h1234_5678);
        checkOutput("range_hi_rresp", r_r, RANGE_EN ? SLVERR : OKAY);
        readWord(BASE, 0, d_r, r_r);
        checkOutput("range_word0", d_r, RANGE_EN ? 32'hCAFE_F00D : 32'h1234_5678);
        applyStimulus(BASE - 32'h4, 32'h0000_0077, 4'b1111, 0, 0, 0, b_r);
        checkOutput("range_lo_bresp", b_r, RANGE_EN ? SLVERR : OKAY);
        readWord(BASE + 32'hFC, 0, d2_r, r_r);
        checkOutput("range_lo_word63", d2_r, RANGE_EN ? 32'h6363_6363 : 32'h0000_0077);

        araddr = BASE + 32'h20; arvalid = 1; rready = 0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(posedge clock); #1; n++;
            if (!arready) arvalid = 0;
        end
        arvalid = 0;
        checkOutput("reset_case_rvalid_up", rvalid, 1);
        @(posedge clock); #1;
        reset_n = 0;
        #1;
        checkOutput("reset_drops_rvalid", rvalid, 0);
        checkOutput("reset_arready_low", arready, 0);
        repeat (2) begin @(posedge clock); #1; end
        reset_n = 1;
        @(negedge clock);
        checkOutput("arready_low_before_edge", arready, 0);
        @(posedge clock); #1;
        checkOutput("arready_one_cycle_after_release", arready, 1);
        readWord(BASE + 32'h10, 0, d_r, r_r);
        checkOutput("ram_kept_over_reset", d_r, 32'hDEAD_BEEF);

        repeat (3) begin @(posedge clock); #1; end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
